// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder emulator and its decoder-side peers:
// phase codes, the step-direction phase function and the emulator state encoding.
package enc_pkg;

    localparam int FILT_CONST   = 15;
    localparam int MIN_HOLD_DEF = FILT_CONST + 5;

    // {A,B} channel codes in forward order
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic fwd);
        logic [1:0] r;
        case (ph)
            PH_00:   r = fwd ? PH_10 : PH_01;
            PH_10:   r = fwd ? PH_11 : PH_00;
            PH_11:   r = fwd ? PH_01 : PH_10;
            default: r = fwd ? PH_00 : PH_11;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/enc_pos_counter.sv
// Modulo-(4*LINES) up/down position counter with a registered zero flag.
// Wraps by comparison, so LINES need not be a power of two.
module enc_pos_counter #(
    parameter int LINES = 1024,
    parameter int POS_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up,
    input  logic             down,
    output logic [POS_W-1:0] count,
    output logic             is_zero
);

    localparam logic [POS_W-1:0] TOP = POS_W'(4 * LINES - 1);

    logic [POS_W-1:0] cnt_d;

    always_comb begin
        cnt_d = count;
        if (up) begin
            cnt_d = (count == TOP) ? '0 : count + POS_W'(1);
        end else if (down) begin
            cnt_d = (count == '0) ? TOP : count - POS_W'(1);
        end
    end

    // Zero flag follows the next value so it changes on the same edge as count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            is_zero <= 1'b1;
        end else begin
            count   <= cnt_d;
            is_zero <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/quad_enc_tx.sv
// Quadrature encoder emulator: turns single-step requests into A/B/Z waveforms,
// holding each phase at least MIN_HOLD clocks so downstream filters see every edge.
module quad_enc_tx
    import enc_pkg::*;
#(
    parameter int MIN_HOLD = MIN_HOLD_DEF,
    parameter int HOLD_W   = 8,
    parameter int LINES    = 1024,
    parameter int POS_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             step_valid,
    input  logic             step_dir,
    output logic             step_ready,
    output logic             Chn_A_out,
    output logic             Chn_B_out,
    output logic             Chn_Z_out,
    output logic [POS_W-1:0] pos_out
);

    // Loading MIN_HOLD-2 puts the next accept exactly MIN_HOLD edges later,
    // accounting for the registered step_ready.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 2);

    enc_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              ready_q, ready_d;
    logic [1:0]        ab_q, ab_d;
    logic              accept;

    // Handshake: a step transfers on a rising edge where step_valid, step_ready
    // and en are all high; step_valid while step_ready is low is dropped, not queued.
    assign accept = en & step_valid & ready_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ready_d = ready_q;
        ab_d    = ab_q;
        case (state_q)
            IDLE: begin
                ready_d = en;
                if (accept) begin
                    ab_d    = next_phase(ab_q, step_dir);
                    hold_d  = HOLD_LOAD;
                    state_d = HOLD;
                    ready_d = 1'b0;
                end
            end
            HOLD: begin
                ready_d = 1'b0;
                // Counts regardless of en so re-enabling never shortens a hold
                if (hold_q == '0) begin
                    state_d = IDLE;
                    ready_d = en;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            ready_q <= 1'b0;
            ab_q    <= PH_00;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
            ab_q    <= ab_d;
        end
    end

    enc_pos_counter #(
        .LINES(LINES),
        .POS_W(POS_W)
    ) u_pos (
        .clk    (clk),
        .rst_n  (rst_n),
        .up     (accept & step_dir),
        .down   (accept & ~step_dir),
        .count  (pos_out),
        .is_zero(Chn_Z_out)
    );

    assign step_ready = ready_q;
    assign Chn_A_out  = ab_q[1];
    assign Chn_B_out  = ab_q[0];

endmodule

// File: tb/tb_quad_enc_tx.sv
// Bench for quad_enc_tx: scenario tasks drive steps, a scoreboard checks every
// output change and a bench-side channel filter checks edges survive filtering.
module tb_quad_enc_tx;

    localparam int MIN_HOLD = 20;
    localparam int LINES    = 4;
    localparam int POS_W    = 4;
    localparam int NPOS     = 4 * LINES;
    localparam int W        = 3 + POS_W;
    localparam int FILT     = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             step_valid = 1'b0;
    logic             step_dir = 1'b0;
    logic             step_ready;
    logic             a, b, z;
    logic [POS_W-1:0] pos;

    quad_enc_tx #(
        .MIN_HOLD(MIN_HOLD),
        .HOLD_W  (8),
        .LINES   (LINES),
        .POS_W   (POS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .step_valid(step_valid),
        .step_dir  (step_dir),
        .step_ready(step_ready),
        .Chn_A_out (a),
        .Chn_B_out (b),
        .Chn_Z_out (z),
        .pos_out   (pos)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // scoreboard: expected {A,B,Z,pos} per accepted step
    logic [W-1:0]  exp_q[$];
    logic [33:0]   lb_q[$];
    int            m_pos = 0;
    int            acc_cyc = 0;
    logic          lb_en = 1'b0;

    function automatic logic [W-1:0] model_vec(input int p);
        logic [POS_W-1:0] pv;
        pv = POS_W'(p);
        return {pv[1] ^ pv[0], pv[1], (p == 0), pv};
    endfunction

    logic [W-1:0] prev_vec;
    logic [W-1:0] cur_vec;
    assign cur_vec = {a, b, z, pos};

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            prev_vec = cur_vec;
        end else if (cur_vec !== prev_vec) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %b, expected no change (cyc %0d)", cur_vec, cyc);
            end else begin
                e = exp_q.pop_front();
                if (cur_vec !== e) begin
                    bad++;
                    $display("FAIL sb_step: got {A,B,Z,pos}=%b, expected %b (cyc %0d)", cur_vec, e, cyc);
                end
            end
            total++;
            if (cur_vec[W-1] !== prev_vec[W-1] && cur_vec[W-2] !== prev_vec[W-2]) begin
                bad++;
                $display("FAIL sb_one_channel: A and B both changed, %b -> %b", prev_vec[W-1 -: 2], cur_vec[W-1 -: 2]);
            end
            prev_vec = cur_vec;
        end
    end

    // bench-side channel debounce filter: sync stage then FILT-cycle stability count
    logic sa, sb, fa, fb;
    int   ca, cb;
    always @(posedge clk) begin
        if (!rst_n) begin
            sa <= 1'b0; sb <= 1'b0; fa <= 1'b0; fb <= 1'b0; ca <= 0; cb <= 0;
        end else begin
            sa <= a;
            sb <= b;
            if (sa != fa) begin
                if (ca == FILT - 1) begin fa <= sa; ca <= 0; end
                else ca <= ca + 1;
            end else ca <= 0;
            if (sb != fb) begin
                if (cb == FILT - 1) begin fb <= sb; cb <= 0; end
                else cb <= cb + 1;
            end else cb <= 0;
        end
    end

    logic [1:0] lb_prev;
    always @(negedge clk) begin
        logic [33:0] e;
        if (lb_en && {fa, fb} !== lb_prev) begin
            total++;
            if (lb_q.size() == 0) begin
                bad++;
                $display("FAIL lb_unexpected: filtered {A,B}=%b%b at cyc %0d, expected none", fa, fb, cyc);
            end else begin
                e = lb_q.pop_front();
                if ({fa, fb, 32'(cyc)} !== e) begin
                    bad++;
                    $display("FAIL lb_edge: got {A,B}=%b%b at cyc %0d, expected %b at cyc %0d",
                             fa, fb, cyc, e[33:32], e[31:0]);
                end
            end
            lb_prev = {fa, fb};
        end
    end

    // driver
    task automatic do_step(input logic dir);
        int n;
        logic [W-1:0] mv;
        n = 0;
        while (step_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (step_ready !== 1'b1) begin
            bad++;
            $display("FAIL step_wait: step_ready=%b after %0d cycles, expected 1", step_ready, n);
        end else begin
            step_valid = 1'b1;
            step_dir   = dir;
            @(posedge clk); #1;
            acc_cyc = cyc;
            m_pos = dir ? (m_pos + 1) % NPOS : (m_pos + NPOS - 1) % NPOS;
            mv = model_vec(m_pos);
            exp_q.push_back(mv);
            if (lb_en) lb_q.push_back({mv[W-1 -: 2], 32'(acc_cyc + FILT + 1)});
            step_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; step_valid = 1'b1; step_dir = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if ({a, b, z, pos, step_ready} !== {3'b001, POS_W'(0), 1'b0}) begin
                bad++;
                $display("FAIL reset_vals: got A%b B%b Z%b pos%0d rdy%b, expected A0 B0 Z1 pos0 rdy0",
                         a, b, z, pos, step_ready);
            end
        end
        rst_n = 1'b1; step_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (step_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: step_ready=%b one clock after release, expected 1", step_ready);
        end
        total++;
        if ({a, b, z, pos} !== {3'b001, POS_W'(0)}) begin
            bad++;
            $display("FAIL reset_hold: got {A,B,Z,pos}=%b, expected 001_0000", {a, b, z, pos});
        end
    endtask

    task automatic test_forward();
        int prev;
        do_step(1'b1);
        for (int i = 0; i < 3; i++) begin
            prev = acc_cyc;
            do_step(1'b1);
            total++;
            if (acc_cyc - prev !== MIN_HOLD) begin
                bad++;
                $display("FAIL fwd_spacing: edge spacing %0d, expected %0d", acc_cyc - prev, MIN_HOLD);
            end
        end
        total++;
        if (pos !== POS_W'(4)) begin
            bad++;
            $display("FAIL fwd_pos: pos=%0d, expected 4", pos);
        end
    endtask

    task automatic test_ignored();
        int base;
        logic [POS_W-1:0] p0;
        do_step(1'b1);
        base = acc_cyc;
        p0 = pos;
        repeat (5) begin @(posedge clk); #1; end
        step_valid = 1'b1; step_dir = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (pos !== p0) begin
            bad++;
            $display("FAIL ignored_pos: pos=%0d after early request, expected %0d", pos, p0);
        end
        do_step(1'b1);
        total++;
        if (acc_cyc - base !== MIN_HOLD) begin
            bad++;
            $display("FAIL ignored_next: next accept after %0d cycles, expected %0d", acc_cyc - base, MIN_HOLD);
        end
    endtask

    task automatic test_wrap();
        while (m_pos != 0) do_step(1'b1);
        for (int i = 0; i < NPOS; i++) begin
            do_step(1'b1);
            total++;
            if (z !== (m_pos == 0)) begin
                bad++;
                $display("FAIL wrap_z: Z=%b at pos %0d, expected %b", z, pos, (m_pos == 0));
            end
        end
        total++;
        if (pos !== POS_W'(0) || z !== 1'b1) begin
            bad++;
            $display("FAIL wrap_fwd: pos=%0d Z=%b, expected pos 0 Z 1", pos, z);
        end
        do_step(1'b0);
        total++;
        if ({a, b, z, pos} !== {2'b01, 1'b0, POS_W'(NPOS - 1)}) begin
            bad++;
            $display("FAIL wrap_rev: got {A,B,Z,pos}=%b, expected 010_1111", {a, b, z, pos});
        end
    endtask

    task automatic test_hold_en();
        int base;
        do_step(1'b1);
        base = acc_cyc;
        en = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        en = 1'b1;
        do_step(1'b1);
        total++;
        if (acc_cyc - base !== MIN_HOLD) begin
            bad++;
            $display("FAIL hold_en: accept after %0d cycles with en gap, expected %0d", acc_cyc - base, MIN_HOLD);
        end
    endtask

    task automatic test_enable_rev();
        int orig;
        int rdy_bad;
        logic [W-1:0] snap;
        while (m_pos != 0) do_step(1'b1);
        orig = m_pos;
        do_step(1'b1);
        snap = cur_vec;
        en = 1'b0; step_valid = 1'b1; step_dir = 1'b1;
        rdy_bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (step_ready !== 1'b0) rdy_bad++;
        end
        total++;
        if (rdy_bad != 0) begin
            bad++;
            $display("FAIL en_ready: step_ready high on %0d cycles with en=0, expected 0", rdy_bad);
        end
        total++;
        if (cur_vec !== snap) begin
            bad++;
            $display("FAIL en_frozen: got {A,B,Z,pos}=%b, expected %b", cur_vec, snap);
        end
        en = 1'b1; step_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (step_ready !== 1'b1) begin
            bad++;
            $display("FAIL en_resume: step_ready=%b one clock after en rise, expected 1", step_ready);
        end
        do_step(1'b0);
        total++;
        if ({a, b} !== 2'b00 || pos !== POS_W'(orig)) begin
            bad++;
            $display("FAIL en_rev: got AB=%b%b pos=%0d, expected AB=00 pos=%0d", a, b, pos, orig);
        end
    endtask

    task automatic test_loopback();
        repeat (2 * MIN_HOLD) begin @(posedge clk); #1; end
        lb_prev = {fa, fb};
        lb_en = 1'b1;
        for (int i = 0; i < 100; i++) do_step(1'(($urandom_range(0, 1))));
        repeat (2 * MIN_HOLD) begin @(posedge clk); #1; end
        lb_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_forward();
        test_ignored();
        test_wrap();
        test_hold_en();
        test_enable_rev();
        test_loopback();
        repeat (5) begin @(posedge clk); #1; end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d expected steps never seen, expected 0", exp_q.size());
        end
        total++;
        if (lb_q.size() != 0) begin
            bad++;
            $display("FAIL lb_drain: %0d filtered edges missing, expected 0", lb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
